// File: rtl/uart_rx_pkg.sv
// Shared widths, default oversampling ratio and sample-point helper for the UART receiver.
package uart_rx_pkg;

  localparam int EDGE_W           = 6;
  localparam int BIT_W            = 4;
  localparam int PRESCALE_DEFAULT = 8;

  // Bit-centre edge index M for a given oversampling ratio.
  function automatic int mid_edge(input int prescale);
    return prescale / 2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter with wrap and synchronous clear on !en_i.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [EDGE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]  bit_cnt_o
);

  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(PRESCALE - 1);

  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (en_i) begin
      if (edge_q == LAST_EDGE) begin
        edge_d = '0;
        bit_d  = bit_q + 1'b1;  // wraps 15 -> 0; the FSM ends the frame
      end else begin
        edge_d = edge_q + 1'b1;
        bit_d  = bit_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end: 3-sample majority vote around each bit centre.
// Define UART_RX_SAMPLER_SYNC_EN to insert a 2-flop synchronizer on rx_in.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              sampled_bit,
  output logic              sample_valid,
  output logic              start_glitch
);

  localparam int M = mid_edge(PRESCALE);
  localparam logic [EDGE_W-1:0] E_S0   = EDGE_W'(M - 1);
  localparam logic [EDGE_W-1:0] E_S1   = EDGE_W'(M);
  localparam logic [EDGE_W-1:0] E_VOTE = EDGE_W'(M + 1);

  logic rx_s;

`ifdef UART_RX_SAMPLER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  uart_rx_edge_bit_cnt #(.PRESCALE(PRESCALE)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (samp_en),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  logic s0_q, s1_q, sampled_q, valid_q, glitch_q;
  logic vote_d;

  assign vote_d = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
      // Counters clear whenever samp_en drops, so a partial vote is never completed.
      if (samp_en) begin
        if (edge_cnt == E_S0) s0_q <= rx_s;
        if (edge_cnt == E_S1) s1_q <= rx_s;
        if (edge_cnt == E_VOTE) begin
          sampled_q <= vote_d;
          valid_q   <= 1'b1;
          glitch_q  <= (bit_cnt == '0) && vote_d;
        end
      end
    end
  end

  assign sampled_bit  = sampled_q;
  assign sample_valid = valid_q;
  assign start_glitch = glitch_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: stimulus pushes expected votes, a monitor pops them.
module tb_uart_rx_sampler;
  import uart_rx_pkg::*;

  localparam int P = 8;
  localparam int M = P / 2;
`ifdef UART_RX_SAMPLER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_in = 1'b1;
  logic              samp_en = 1'b0;
  logic [EDGE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sampled_bit, sample_valid, start_glitch;

  uart_rx_sampler #(.PRESCALE(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .samp_en      (samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .start_glitch (start_glitch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       b;
    logic [3:0] bc;
    logic       g;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic line_v[0:255];
  int   line_len = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_line();
    line_len = 0;
  endtask

  task automatic add_bit(input logic v);
    for (int k = 0; k < P; k++) begin
      line_v[line_len] = v;
      line_len++;
    end
  endtask

  task automatic push(input logic b, input int bc, input logic g);
    exp_t e;
    e.b = b; e.bc = 4'(bc); e.g = g;
    exp_q.push_back(e);
  endtask

  // Line value for enabled cycle k must appear on rx_s in that cycle, so rx_in leads by LAT.
  task automatic play(input int ncyc, input bit keep);
    for (int i = -LAT; i < ncyc; i++) begin
      rx_in = (i + LAT < line_len) ? line_v[i + LAT] : 1'b1;
      if (i == 0) samp_en = 1'b1;
      @(posedge clk); #1;
    end
    if (!keep) begin
      samp_en = 1'b0;
      rx_in   = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sampled_bit", int'(sampled_bit), int'(e.b));
        chk("bit_cnt_at_vote", int'(bit_cnt), int'(e.bc));
        chk("edge_cnt_at_vote", int'(edge_cnt), M + 2);
        chk("start_glitch", int'(start_glitch), int'(e.g));
      end
    end else if (!rst && start_glitch) begin
      chk("glitch_without_valid", 1, 0);
    end
  end

  initial begin
    logic [8:0] frame;
    frame = 9'b0_10100101;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edge_cnt", int'(edge_cnt), 0);
    chk("rst_bit_cnt", int'(bit_cnt), 0);
    chk("rst_sampled_bit", int'(sampled_bit), 1);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_start_glitch", int'(start_glitch), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean frame: start 0 then 10100101
    clear_line();
    for (int i = 0; i < 9; i++) begin
      add_bit(frame[8 - i]);
      push(frame[8 - i], i, 1'b0);
    end
    play(9 * P, 1'b0);

    // Single-clock glitch at edge M on a bit held at 1
    clear_line();
    add_bit(1'b0); add_bit(1'b1);
    line_v[P + M] = 1'b0;
    push(1'b0, 0, 1'b0); push(1'b1, 1, 1'b0);
    play(2 * P, 1'b0);

    // Glitch spanning edges M-1..M wins the vote
    clear_line();
    add_bit(1'b0); add_bit(1'b1);
    line_v[P + M - 1] = 1'b0;
    line_v[P + M]     = 1'b0;
    push(1'b0, 0, 1'b0); push(1'b0, 1, 1'b0);
    play(2 * P, 1'b0);

    // False start: line high across the three sample points
    clear_line();
    add_bit(1'b0);
    for (int k = M - 1; k <= M + 1; k++) line_v[k] = 1'b1;
    push(1'b1, 0, 1'b1);
    play(P, 1'b0);

    // samp_en dropped at edge 4 of bit 2
    clear_line();
    add_bit(1'b0); add_bit(1'b1); add_bit(1'b0);
    push(1'b0, 0, 1'b0); push(1'b1, 1, 1'b0);
    play(2 * P + 4, 1'b1);
    chk("pre_drop_edge_cnt", int'(edge_cnt), 4);
    chk("pre_drop_bit_cnt", int'(bit_cnt), 2);
    samp_en = 1'b0;
    rx_in   = 1'b1;
    @(posedge clk); #1;
    chk("drop_edge_cnt", int'(edge_cnt), 0);
    chk("drop_bit_cnt", int'(bit_cnt), 0);
    repeat (P) @(posedge clk);
    #1;
    chk("drop_no_stale_votes", exp_q.size(), 0);

    // Re-enable restarts from bit 0
    clear_line();
    add_bit(1'b0); add_bit(1'b1);
    push(1'b0, 0, 1'b0); push(1'b1, 1, 1'b0);
    play(2 * P, 1'b0);

    // Asynchronous reset mid-frame at edge 5 of bit 3
    clear_line();
    add_bit(1'b0); add_bit(1'b1); add_bit(1'b0); add_bit(1'b1);
    push(1'b0, 0, 1'b0); push(1'b1, 1, 1'b0); push(1'b0, 2, 1'b0);
    play(3 * P + 5, 1'b1);
    chk("pre_rst_edge_cnt", int'(edge_cnt), 5);
    chk("pre_rst_bit_cnt", int'(bit_cnt), 3);
    chk("pre_rst_sampled_bit", int'(sampled_bit), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_edge_cnt", int'(edge_cnt), 0);
    chk("async_rst_bit_cnt", int'(bit_cnt), 0);
    chk("async_rst_sampled_bit", int'(sampled_bit), 1);
    chk("async_rst_sample_valid", int'(sample_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("resume_edge_cnt", int'(edge_cnt), 1);
    chk("resume_bit_cnt", int'(bit_cnt), 0);
    samp_en = 1'b0;
    @(posedge clk); #1;

    // Frame again after reset
    clear_line();
    for (int i = 0; i < 9; i++) begin
      add_bit(frame[8 - i]);
      push(frame[8 - i], i, 1'b0);
    end
    play(9 * P, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_votes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
